// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern generator: pattern modes, engine
// states, ping-pong directions and the divider terminal-count helper.
// Optional feature macro used by this slice: LED_PATTERN_SPEED_EN.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_SHL   = 2'd0,
    MODE_SHR   = 2'd1,
    MODE_PING  = 2'd2,
    MODE_BLINK = 2'd3
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // Terminal count of the divider for a given period and speed shift.
  function automatic int unsigned divTc(input int unsigned div, input logic [1:0] speed);
    return (div >> speed) - 1;
  endfunction

endpackage

// File: rtl/led_pattern_gen_tick_div.sv
// Clock-enable divider for the LED pattern generator. Counts clk cycles while
// en is high and flags the terminal-count cycle; the registered step pulse
// follows one cycle later. With LED_PATTERN_SPEED_EN defined a speed input
// shortens the period to DIV, DIV/2, DIV/4 or DIV/8.
module tick_div
  import led_pkg::*;
#(
  parameter int DIV = 6_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
`ifdef LED_PATTERN_SPEED_EN
  input  logic [1:0] speed,
`endif
  output logic       wrap,
  output logic       step
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_step;
  logic [CW-1:0] w_tc;

`ifdef LED_PATTERN_SPEED_EN
  logic [1:0] r_speed;

  assign w_tc = CW'(divTc(DIV, r_speed));

  // Take a new speed only at the wrap so every period is a whole one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_speed <= 2'd0;
    end else if (wrap) begin
      r_speed <= speed;
    end
  end
`else
  assign w_tc = CW'(divTc(DIV, 2'd0));
`endif

  assign wrap = en && (r_cnt == w_tc);
  assign step = r_step;

  // Cycle counter: wraps at the terminal count, holds while disabled, and
  // recovers to zero if it ever sits above a shortened terminal count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (r_cnt > w_tc) begin
      r_cnt <= '0;
    end else if (en) begin
      if (r_cnt == w_tc) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Step pulse is high for the single cycle after each wrap edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_step <= 1'b0;
    end else begin
      r_step <= wrap;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator top: a tick divider paces a pattern engine with
// shift-left, shift-right, ping-pong and blink modes on an active-low LED bank.
// Optional feature macro: LED_PATTERN_SPEED_EN adds the speed input.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int LED_W = 8,
  parameter int DIV   = 6_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
`ifdef LED_PATTERN_SPEED_EN
  input  logic [1:0]       speed,
`endif
  output logic [LED_W-1:0] led,
  output logic             step
);

  logic             w_wrap;
  logic             w_step;
  mode_t            w_mode;
  logic [LED_W-1:0] w_lit;

  state_t           r_state;
  mode_t            r_mode;
  logic             r_dir;
  logic [LED_W-1:0] r_led;

  tick_div #(
    .DIV(DIV)
  ) u_tick_div (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
`ifdef LED_PATTERN_SPEED_EN
    .speed(speed),
`endif
    .wrap (w_wrap),
    .step (w_step)
  );

  assign w_mode = mode_t'(mode);
  assign w_lit  = ~r_led;
  assign led    = r_led;
  assign step   = w_step;

  // Lit-bit pattern each mode starts from when entered or restarted.
  function automatic logic [LED_W-1:0] startLit(input mode_t m);
    logic [LED_W-1:0] lit;
    case (m)
      MODE_SHR:   lit = {1'b1, {(LED_W-1){1'b0}}};
      MODE_BLINK: lit = '1;
      default:    lit = LED_W'(1);
    endcase
    return lit;
  endfunction

  // Pattern engine: on each wrap either (re)start the sampled mode or advance
  // the active one; the LED register updates on the same edge as step rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_SHL;
      r_dir   <= DIR_UP;
      r_led   <= '1;
    end else if (w_wrap) begin
      if ((r_state == ST_IDLE) || (w_mode != r_mode)) begin
        r_state <= ST_RUN;
        r_mode  <= w_mode;
        r_dir   <= DIR_UP;
        r_led   <= ~startLit(w_mode);
      end else begin
        case (r_mode)
          MODE_SHL: r_led <= ~{w_lit[LED_W-2:0], w_lit[LED_W-1]};
          MODE_SHR: r_led <= ~{w_lit[0], w_lit[LED_W-1:1]};
          MODE_PING: begin
            if (r_dir == DIR_UP) begin
              if (w_lit[LED_W-1]) begin
                r_dir <= DIR_DN;
                r_led <= ~(w_lit >> 1);
              end else begin
                r_led <= ~(w_lit << 1);
              end
            end else begin
              if (w_lit[0]) begin
                r_dir <= DIR_UP;
                r_led <= ~(w_lit << 1);
              end else begin
                r_led <= ~(w_lit >> 1);
              end
            end
          end
          MODE_BLINK: r_led <= ~r_led;
          default: r_led <= r_led;
        endcase
      end
    end
  end

endmodule
